// File: rtl/lpddr2_cpu_bridge_pkg.sv
// Shared types and constants for the CPU-to-LPDDR2 Avalon-MM bridge.
package lpddr2_bridge_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_DONE
  } bridge_state_t;

  localparam logic [31:0] DEFAULT_ERR_WORD = 32'hDEADBEEF;
  localparam logic        AVM_BURSTCOUNT   = 1'b1;
  localparam logic        AVM_BYTE_EN      = 1'b1;

endpackage

// File: rtl/lpddr2_cpu_bridge_if.sv
// CPU request bundle plus controller Avalon-MM slave signals, seen from both sides.
interface lpddr2_cpu_bridge_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   cpu_address;
  logic [DATA_W-1:0]   cpu_write_data;
  logic                cpu_rreq;
  logic                cpu_wreq;
  logic [DATA_W-1:0]   cpu_read_data;
  logic                cpu_busy;
  logic                cpu_done;
  logic                err_timeout;
  logic                local_init_done;
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_burstcount;
  logic                avm_read;
  logic                avm_write;
  logic                avm_waitrequest;
  logic                avm_readdatavalid;
  logic [DATA_W-1:0]   avm_readdata;

  // slave: the bridge, serving CPU requests; master: the CPU plus the controller around it
  modport slave (
    input  cpu_address, cpu_write_data, cpu_rreq, cpu_wreq, local_init_done,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata,
    output cpu_read_data, cpu_busy, cpu_done, err_timeout,
    output avm_address, avm_writedata, avm_byteenable, avm_burstcount, avm_read, avm_write
  );

  modport master (
    output cpu_address, cpu_write_data, cpu_rreq, cpu_wreq, local_init_done,
    output avm_waitrequest, avm_readdatavalid, avm_readdata,
    input  cpu_read_data, cpu_busy, cpu_done, err_timeout,
    input  avm_address, avm_writedata, avm_byteenable, avm_burstcount, avm_read, avm_write
  );
endinterface

// File: rtl/lpddr2_cpu_bridge_timeout.sv
// Outstanding-transaction watchdog: flags expiry once TIMEOUT_CYCLES-1 enabled cycles elapse.
module bridge_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int               CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && !expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = (r_count == LAST);
endmodule

// File: rtl/lpddr2_cpu_bridge.sv
// Turns level-style CPU read/write requests into single-beat Avalon-MM transactions,
// one per request assertion, with registered read data and a sticky timeout flag.
module lpddr2_cpu_bridge
  import lpddr2_bridge_pkg::*;
#(
  parameter int                ADDR_W         = 27,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_WORD       = DATA_W'(DEFAULT_ERR_WORD)
) (
  input logic                clk,
  input logic                rst,
  lpddr2_cpu_bridge_if.slave io_bus
);
  bridge_state_t     r_state;
  bridge_state_t     w_next_state;
  logic              r_armed;
  logic [ADDR_W-1:0] r_avm_address;
  logic [DATA_W-1:0] r_avm_writedata;
  logic [DATA_W-1:0] r_cpu_read_data;
  logic              r_avm_read;
  logic              r_avm_write;
  logic              r_cpu_done;
  logic              r_err_timeout;

  logic              w_req;
  logic              w_accept;
  logic              w_cnt_en;
  logic              w_expired;
  logic              w_load_rdata;
  logic              w_timeout;
  logic [DATA_W-1:0] w_rdata_next;

  assign w_req    = io_bus.cpu_wreq | io_bus.cpu_rreq;
  assign w_accept = (r_state == ST_IDLE) && r_armed && w_req;
  assign w_cnt_en = (r_state == ST_WR) || (r_state == ST_RD_CMD) || (r_state == ST_RD_WAIT);

  bridge_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_accept),
    .en     (w_cnt_en),
    .expired(w_expired)
  );

  // A genuine completion in the expiry cycle wins over the timeout.
  always_comb begin
    w_next_state = r_state;
    w_load_rdata = 1'b0;
    w_rdata_next = io_bus.avm_readdata;
    w_timeout    = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (io_bus.local_init_done) w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_accept) w_next_state = io_bus.cpu_wreq ? ST_WR : ST_RD_CMD;
      end
      ST_WR: begin
        if (!io_bus.avm_waitrequest) begin
          w_next_state = ST_DONE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_RD_CMD: begin
        if (!io_bus.avm_waitrequest && io_bus.avm_readdatavalid) begin
          w_load_rdata = 1'b1;
          w_next_state = ST_DONE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_load_rdata = 1'b1;
          w_rdata_next = ERR_WORD;
          w_next_state = ST_DONE;
        end else if (!io_bus.avm_waitrequest) begin
          w_next_state = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (io_bus.avm_readdatavalid) begin
          w_load_rdata = 1'b1;
          w_next_state = ST_DONE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_load_rdata = 1'b1;
          w_rdata_next = ERR_WORD;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_INIT;
    endcase
  end

  // Command and done strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_INIT;
      r_armed         <= 1'b1;
      r_avm_address   <= '0;
      r_avm_writedata <= '0;
      r_cpu_read_data <= '0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_cpu_done      <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_armed <= 1'b0;
      end else if (!w_req) begin
        r_armed <= 1'b1;
      end
      if (w_accept) begin
        r_avm_address   <= io_bus.cpu_address;
        r_avm_writedata <= io_bus.cpu_write_data;
      end
      r_avm_write <= (w_next_state == ST_WR);
      r_avm_read  <= (w_next_state == ST_RD_CMD);
      r_cpu_done  <= (w_next_state == ST_DONE);
      if (w_load_rdata) r_cpu_read_data <= w_rdata_next;
      if (w_timeout)    r_err_timeout   <= 1'b1;
    end
  end

  assign io_bus.cpu_busy       = (r_state != ST_IDLE) || w_accept;
  assign io_bus.cpu_read_data  = r_cpu_read_data;
  assign io_bus.cpu_done       = r_cpu_done;
  assign io_bus.err_timeout    = r_err_timeout;
  assign io_bus.avm_address    = r_avm_address;
  assign io_bus.avm_writedata  = r_avm_writedata;
  assign io_bus.avm_read       = r_avm_read;
  assign io_bus.avm_write      = r_avm_write;
  assign io_bus.avm_burstcount = AVM_BURSTCOUNT;
  assign io_bus.avm_byteenable = {(DATA_W/8){AVM_BYTE_EN}};
endmodule

// File: tb/tb_lpddr2_cpu_bridge.sv
// Randomized bench: an Avalon slave responder plus a transaction-level expectation model.
module tb_lpddr2_cpu_bridge;
  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lpddr2_cpu_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  lpddr2_cpu_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .ERR_WORD(ERR_WORD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Controller responder knobs and logs
  int          wait_cycles = 0;
  int          rd_latency  = 1;
  bit          no_reply    = 1'b0;
  logic [31:0] rd_word     = '0;
  bit          stray_en    = 1'b0;
  int          wait_cnt    = 0;
  bit          cmd_active  = 1'b0;
  bit          rd_pending  = 1'b0;
  int          rd_delay    = 0;
  logic [31:0] pend_word   = '0;
  int          wr_count    = 0;
  int          rd_count    = 0;
  int          unstable    = 0;
  logic [26:0] first_addr  = '0;
  logic [31:0] first_wdata = '0;
  logic [26:0] log_addr    = '0;
  logic [31:0] log_wdata   = '0;

  always @(negedge clk) begin
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = $urandom;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = pend_word;
        rd_pending            = 1'b0;
      end else begin
        rd_delay--;
      end
    end else if (stray_en && !bus.cpu_busy && $urandom_range(0, 3) == 0) begin
      bus.avm_readdatavalid = 1'b1;
    end
    if (bus.avm_read || bus.avm_write) begin
      if (!cmd_active) begin
        cmd_active  = 1'b1;
        wait_cnt    = 0;
        first_addr  = bus.avm_address;
        first_wdata = bus.avm_writedata;
      end else if (bus.avm_address !== first_addr || bus.avm_writedata !== first_wdata) begin
        unstable++;
      end
      if (wait_cnt < wait_cycles) begin
        bus.avm_waitrequest = 1'b1;
        wait_cnt++;
      end else begin
        bus.avm_waitrequest = 1'b0;
        cmd_active          = 1'b0;
        log_addr            = bus.avm_address;
        if (bus.avm_write) begin
          wr_count++;
          log_wdata = bus.avm_writedata;
        end
        if (bus.avm_read) begin
          rd_count++;
          if (!no_reply) begin
            if (rd_latency == 0) begin
              bus.avm_readdatavalid = 1'b1;
              bus.avm_readdata      = rd_word;
            end else begin
              rd_pending = 1'b1;
              rd_delay   = rd_latency - 1;
              pend_word  = rd_word;
            end
          end
        end
      end
    end else begin
      cmd_active          = 1'b0;
      bus.avm_waitrequest = 1'($urandom_range(0, 1));
    end
  end

  // Expected architectural state
  logic [31:0] exp_rdata = '0;
  bit          exp_err   = 1'b0;
  int          txn_no    = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // kind: 0 read, 1 write, 2 both requests high (write wins)
  task automatic run_txn(input int kind, input logic [26:0] addr, input logic [31:0] wdata,
                         input int w, input int lat, input bit noreply,
                         input logic [31:0] word, input int hold);
    int wr0, rd0, dones, lat_seen, exp_lat;
    wr0 = wr_count; rd0 = rd_count; dones = 0; lat_seen = -1;
    wait_cycles = w; rd_latency = lat; no_reply = noreply; rd_word = word;
    bus.cpu_address    = addr;
    bus.cpu_write_data = wdata;
    bus.cpu_wreq       = (kind != 0);
    bus.cpu_rreq       = (kind != 1);
    #1;
    check_val("busy_on_accept", 32'(bus.cpu_busy), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      bus.cpu_address    = 27'($urandom);
      bus.cpu_write_data = $urandom;
      if (bus.cpu_done) begin
        dones++;
        if (lat_seen < 0) lat_seen = k;
      end
      if (k >= hold) begin
        bus.cpu_wreq = 1'b0;
        bus.cpu_rreq = 1'b0;
      end
    end
    if (kind == 0) begin
      exp_lat   = noreply ? TMO + 1 : 2 + w + lat;
      exp_rdata = noreply ? ERR_WORD : word;
      exp_err   = exp_err | noreply;
    end else begin
      exp_lat = 2 + w;
    end
    txn_no++;
    $display("txn %0d kind=%0d addr=%h w=%0d lat=%0d noreply=%0d hold=%0d done_at=%0d dones=%0d",
             txn_no, kind, addr, w, lat, noreply, hold, lat_seen, dones);
    check_val("done_count", 32'(dones), 32'd1);
    check_val("done_latency", 32'(lat_seen), 32'(exp_lat));
    check_val("write_count", 32'(wr_count - wr0), (kind == 0) ? 32'd0 : 32'd1);
    check_val("read_count", 32'(rd_count - rd0), (kind == 0) ? 32'd1 : 32'd0);
    check_val("cmd_address", 32'(log_addr), 32'(addr));
    if (kind != 0) check_val("cmd_writedata", log_wdata, wdata);
    check_val("cpu_read_data", bus.cpu_read_data, exp_rdata);
    check_val("err_timeout", 32'(bus.err_timeout), 32'(exp_err));
    check_val("cmd_stable", 32'(unstable), 32'd0);
    check_val("idle_not_busy", 32'(bus.cpu_busy), 32'd0);
  endtask

  task automatic run_random(input int n);
    int kind;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 2);
      run_txn(kind, 27'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 3),
              (kind == 0) && ($urandom_range(0, 7) == 0), $urandom, $urandom_range(1, 20));
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit saw_read, not_busy;
    int dones;
    bus.cpu_address     = '0;
    bus.cpu_write_data  = '0;
    bus.cpu_rreq        = 1'b0;
    bus.cpu_wreq        = 1'b0;
    bus.local_init_done = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_val("rst_avm_read", 32'(bus.avm_read), 32'd0);
    check_val("rst_avm_write", 32'(bus.avm_write), 32'd0);
    check_val("rst_cpu_done", 32'(bus.cpu_done), 32'd0);
    check_val("rst_err", 32'(bus.err_timeout), 32'd0);
    check_val("rst_address", 32'(bus.avm_address), 32'd0);
    check_val("rst_writedata", bus.avm_writedata, 32'd0);
    check_val("rst_read_data", bus.cpu_read_data, 32'd0);
    check_val("rst_busy", 32'(bus.cpu_busy), 32'd1);
    check_val("byteenable", 32'(bus.avm_byteenable), 32'hF);
    check_val("burstcount", 32'(bus.avm_burstcount), 32'd1);
    tick();
    rst = 1'b0;

    // Calibration gate: a held read must wait for local_init_done, then issue once.
    wait_cycles = 0; rd_latency = 1; no_reply = 1'b0; rd_word = $urandom;
    bus.cpu_address = 27'h0000ABC;
    bus.cpu_rreq    = 1'b1;
    saw_read = 1'b0; not_busy = 1'b0;
    repeat (10) begin
      tick();
      if (bus.avm_read) saw_read = 1'b1;
      if (!bus.cpu_busy) not_busy = 1'b1;
    end
    check_val("calib_no_read", 32'(saw_read), 32'd0);
    check_val("calib_busy", 32'(not_busy), 32'd0);
    bus.local_init_done = 1'b1;
    dones = 0;
    repeat (25) begin
      tick();
      if (bus.cpu_done) dones++;
    end
    bus.cpu_rreq = 1'b0;
    repeat (3) tick();
    exp_rdata = rd_word;
    check_val("calib_one_read", 32'(rd_count), 32'd1);
    check_val("calib_one_done", 32'(dones), 32'd1);
    check_val("calib_address", 32'(log_addr), 32'h0000ABC);
    check_val("calib_read_data", bus.cpu_read_data, exp_rdata);
    stray_en = 1'b1;

    run_txn(0, 27'h0000040, 32'h0, 0, 1, 1'b0, 32'h2402000A, 2);
    run_txn(1, 27'h0000100, 32'hCAFEF00D, 4, 0, 1'b0, 32'h0, 20);
    run_txn(2, 27'h0000200, 32'h13572468, 1, 0, 1'b0, 32'h0, 5);
    run_txn(0, 27'h0000300, 32'h0, 0, 0, 1'b1, 32'h0, 3);
    run_random(40);

    // Reset while a read is waiting for its data; the late data must be dropped.
    wait_cycles = 0; rd_latency = 6; no_reply = 1'b0; rd_word = 32'h12345678;
    bus.cpu_address = 27'h0000055;
    bus.cpu_rreq    = 1'b1;
    tick();
    check_val("rstmid_cmd", 32'(bus.avm_read), 32'd1);
    tick();
    bus.cpu_rreq        = 1'b0;
    bus.local_init_done = 1'b0;
    rst                 = 1'b1;
    #1;
    check_val("rstmid_read_drop", 32'(bus.avm_read), 32'd0);
    check_val("rstmid_read_data", bus.cpu_read_data, 32'd0);
    check_val("rstmid_err_clear", 32'(bus.err_timeout), 32'd0);
    check_val("rstmid_busy", 32'(bus.cpu_busy), 32'd1);
    repeat (2) tick();
    rst = 1'b0;
    dones = 0; not_busy = 1'b0;
    repeat (10) begin
      tick();
      if (bus.cpu_done) dones++;
      if (!bus.cpu_busy) not_busy = 1'b1;
    end
    bus.local_init_done = 1'b1;
    repeat (3) tick();
    exp_rdata = '0;
    exp_err   = 1'b0;
    check_val("rstmid_no_done", 32'(dones), 32'd0);
    check_val("rstmid_init_busy", 32'(not_busy), 32'd0);
    check_val("rstmid_idle", 32'(bus.cpu_busy), 32'd0);
    check_val("rstmid_late_data", bus.cpu_read_data, 32'd0);
    run_random(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
